sar_avg_sequencer: RTL and testbench

- Downstream companion of the 6-bit SAR binary-search FSM.
- Issues start pulses to the SAR and captures each result when end-of-conversion rises.
- Accumulates 2^LogN consecutive conversions and presents their truncated mean on a valid/ready output port.
- Stalls further conversions under output backpressure; flags a missing end-of-conversion via timeout.

---
 rtl/sar_avg_sequencer_if.sv | 28 ++
 rtl/sar_avg_sequencer.sv | 128 ++++++++++++
 tb/tb_sar_avg_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sar_avg_sequencer_if.sv
// Handshake bundle linking the averaging sequencer to its SAR converter and to the
// consumer of the averaged result.
interface sar_avg_sequencer_if #(
   parameter int Width = 6
);
   logic             en_i;
   logic             clear_i;
   logic             eoc_i;
   logic [Width-1:0] result_i;
   logic             start_o;
   logic [Width-1:0] avg_o;
   logic             valid_o;
   logic             ready_i;
   logic             err_o;
   logic             busy_o;

   // Sequencer side.
   modport slave (
      input  en_i, clear_i, eoc_i, result_i, ready_i,
      output start_o, avg_o, valid_o, err_o, busy_o
   );

   // Environment side: the SAR converter, the run control and the consumer.
   modport master (
      output en_i, clear_i, eoc_i, result_i, ready_i,
      input  start_o, avg_o, valid_o, err_o, busy_o
   );
endinterface

// File: rtl/sar_avg_sequencer.sv
// Starts SAR conversions, sums 2^LogN results and offers their truncated mean on a
// valid/ready port. A watchdog raises a sticky error when end-of-conversion never arrives.
module sar_avg_sequencer #(
   parameter int Width         = 6,
   parameter int LogN          = 2,
   parameter int TimeoutCycles = 64
) (
   input logic                clk_i,
   input logic                rst_ni,
   sar_avg_sequencer_if.slave bus
);

   localparam int AccW = Width + LogN;
   localparam int TmoW = $clog2(TimeoutCycles + 1);
   localparam logic [LogN-1:0] CntLast = '1;
   localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT,
      OUT,
      HOLD
   } StateE;

   StateE            state_q;
   logic [AccW-1:0]  acc_q;
   logic [LogN-1:0]  cnt_q;
   logic [TmoW-1:0]  tmo_q;
   logic             eoc_q;
   logic             start_q;
   logic             valid_q;
   logic             err_q;
   logic [Width-1:0] avg_q;
   logic             eocRise;

   assign eocRise     = bus.eoc_i & ~eoc_q;

   assign bus.start_o = start_q;
   assign bus.avg_o   = avg_q;
   assign bus.valid_o = valid_q;
   assign bus.err_o   = err_q;
   assign bus.busy_o  = (state_q != IDLE);

   // start_q is asserted together with every transition into START, so it is high for
   // exactly the one cycle spent in START. A partial burst keeps cycling through
   // START regardless of en_i; only the hand-off point in HOLD looks at en_i.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         tmo_q   <= '0;
         eoc_q   <= 1'b0;
         start_q <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         avg_q   <= '0;
      end else begin
         eoc_q   <= bus.eoc_i;
         start_q <= 1'b0;
         if (bus.clear_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
         end else begin
            unique case (state_q)
               IDLE: begin
                  if (bus.en_i) begin
                     state_q <= START;
                     start_q <= 1'b1;
                  end
               end
               START: begin
                  tmo_q   <= '0;
                  state_q <= WAIT;
               end
               WAIT: begin
                  // A fresh edge outranks a watchdog expiry in the same cycle.
                  if (eocRise) begin
                     acc_q <= acc_q + AccW'(bus.result_i);
                     cnt_q <= cnt_q + LogN'(1);
                     tmo_q <= '0;
                     if (cnt_q == CntLast) begin
                        state_q <= OUT;
                     end else begin
                        state_q <= START;
                        start_q <= 1'b1;
                     end
                  end else if (tmo_q == TmoLast) begin
                     err_q   <= 1'b1;
                     acc_q   <= '0;
                     cnt_q   <= '0;
                     state_q <= IDLE;
                  end else begin
                     tmo_q <= tmo_q + TmoW'(1);
                  end
               end
               OUT: begin
                  avg_q   <= acc_q[AccW-1:LogN];
                  valid_q <= 1'b1;
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  state_q <= HOLD;
               end
               HOLD: begin
                  if (bus.ready_i) begin
                     valid_q <= 1'b0;
                     if (bus.en_i) begin
                        state_q <= START;
                        start_q <= 1'b1;
                     end else begin
                        state_q <= IDLE;
                     end
                  end
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sar_avg_sequencer.sv
// Self-checking bench: a behavioural SAR answers every start pulse, and a scoreboard
// predicts each delivered average from the raw samples handed to the sequencer.
module tb_sar_avg_sequencer;

   localparam int Width         = 6;
   localparam int LogN          = 2;
   localparam int TimeoutCycles = 64;
   localparam int N             = 1 << LogN;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   sar_avg_sequencer_if #(.Width(Width)) bus ();

   sar_avg_sequencer #(
      .Width(Width),
      .LogN(LogN),
      .TimeoutCycles(TimeoutCycles)
   ) dut (
      .clk_i(clk),
      .rst_ni(rst_n),
      .bus(bus)
   );

   int         vectorCount = 0;
   int         missCount   = 0;
   int         planQ[$];
   int         expQ[$];
   int         seenQ[$];
   int         countdown     = 0;
   int         eocDelay      = 5;
   bit         randDelay     = 1'b0;
   bit         sarMute       = 1'b0;
   int         burstSum      = 0;
   int         burstCnt      = 0;
   int         startCount    = 0;
   int         startsSinceHs = 0;
   int         hsCount       = 0;
   bit         prevHold      = 1'b0;
   int         prevAvg       = 0;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic resetModel();
      countdown     = 0;
      burstSum      = 0;
      burstCnt      = 0;
      startsSinceHs = 0;
      prevHold      = 1'b0;
      expQ.delete();
      bus.eoc_i     = 1'b0;
   endtask

   // One clock cycle: output checks on the current cycle, then the SAR model and
   // scoreboard react to whatever the sequencer shows after the next falling edge.
   task automatic applyStimulus();
      bit hs;
      bit enAtHs;
      int r;
      hs     = 1'b0;
      enAtHs = 1'b0;
      if (prevHold) begin
         checkOutput("valid_stall", bus.valid_o, 1);
         checkOutput("avg_stall", bus.avg_o, prevAvg);
      end
      if (bus.valid_o) begin
         checkOutput("start_in_hold", bus.start_o, 0);
         if (bus.ready_i) begin
            hs     = 1'b1;
            enAtHs = bus.en_i;
            hsCount++;
            seenQ.push_back(int'(bus.avg_o));
            checkOutput("starts_per_burst", startsSinceHs, N);
            startsSinceHs = 0;
            if (expQ.size() == 0) checkOutput("unexpected_valid", bus.valid_o, 0);
            else checkOutput("avg", bus.avg_o, expQ.pop_front());
         end
      end
      prevHold = bus.valid_o && !bus.ready_i && !bus.clear_i;
      prevAvg  = int'(bus.avg_o);
      @(negedge clk);
      if (hs) begin
         checkOutput("valid_drop", bus.valid_o, 0);
         checkOutput("next_start", bus.start_o, int'(enAtHs));
         checkOutput("busy_after_hs", bus.busy_o, int'(enAtHs));
      end
      if (bus.start_o) begin
         startCount++;
         startsSinceHs++;
         bus.eoc_i = 1'b0;
         if (sarMute) countdown = 0;
         else if (randDelay) countdown = $urandom_range(1, 8);
         else countdown = eocDelay;
      end else if (countdown > 0) begin
         countdown--;
         if (countdown == 0) begin
            if (planQ.size() != 0) r = planQ.pop_front();
            else r = $urandom_range(0, (1 << Width) - 1);
            bus.result_i = Width'(r);
            bus.eoc_i    = 1'b1;
            burstSum += r;
            burstCnt++;
            if (burstCnt == N) begin
               expQ.push_back(burstSum / N);
               burstSum = 0;
               burstCnt = 0;
            end
         end else begin
            bus.result_i = Width'($urandom_range(0, (1 << Width) - 1));
         end
      end else begin
         bus.result_i = Width'($urandom_range(0, (1 << Width) - 1));
      end
   endtask

   task automatic doClear();
      bus.clear_i = 1'b1;
      applyStimulus();
      bus.clear_i = 1'b0;
      resetModel();
   endtask

   task automatic waitHandshakes(input int count, input int budget);
      int target;
      int g;
      target = hsCount + count;
      g      = 0;
      while (hsCount < target && g < budget) begin
         applyStimulus();
         g++;
      end
      checkOutput("hs_reached", hsCount, target);
   endtask

   task automatic drainToIdle();
      int g;
      g = 0;
      bus.en_i    = 1'b0;
      bus.ready_i = 1'b1;
      applyStimulus();
      while ((bus.busy_o || expQ.size() != 0) && g < 600) begin
         applyStimulus();
         g++;
      end
      checkOutput("drain_idle", bus.busy_o, 0);
      checkOutput("drain_pending", expQ.size(), 0);
   endtask

   initial begin
      int g;
      int n;
      int h0;
      int s0;
      bus.en_i     = 1'b0;
      bus.clear_i  = 1'b0;
      bus.eoc_i    = 1'b0;
      bus.result_i = '0;
      bus.ready_i  = 1'b1;
      rst_n        = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_start", bus.start_o, 0);
      checkOutput("rst_avg", bus.avg_o, 0);
      checkOutput("rst_valid", bus.valid_o, 0);
      checkOutput("rst_err", bus.err_o, 0);
      checkOutput("rst_busy", bus.busy_o, 0);
      rst_n = 1'b1;
      applyStimulus();

      $display("[TB] fixed burst 10,11,12,13");
      seenQ.delete();
      planQ = '{10, 11, 12, 13};
      bus.en_i = 1'b1;
      waitHandshakes(1, 300);
      checkOutput("first_avg", seenQ[0], 11);
      drainToIdle();

      $display("[TB] full-scale and truncation bursts");
      seenQ.delete();
      planQ = '{63, 63, 63, 63, 0, 0, 0, 3};
      bus.en_i = 1'b1;
      waitHandshakes(2, 400);
      checkOutput("fullscale_avg", seenQ[0], 63);
      checkOutput("trunc_avg", seenQ[1], 0);
      drainToIdle();

      $display("[TB] output backpressure");
      bus.en_i    = 1'b1;
      bus.ready_i = 1'b0;
      g = 0;
      while (!bus.valid_o && g < 300) begin
         applyStimulus();
         g++;
      end
      checkOutput("stall_valid_seen", bus.valid_o, 1);
      repeat (10) applyStimulus();
      bus.ready_i = 1'b1;
      applyStimulus();
      applyStimulus();
      drainToIdle();

      $display("[TB] missing end-of-conversion");
      sarMute  = 1'b1;
      s0       = startCount;
      bus.en_i = 1'b1;
      g = 0;
      while (startCount == s0 && g < 20) begin
         applyStimulus();
         g++;
      end
      checkOutput("tmo_start_seen", startCount, s0 + 1);
      n = 0;
      while (!bus.err_o && n < 200) begin
         applyStimulus();
         n++;
      end
      bus.en_i = 1'b0;
      checkOutput("tmo_latency", n, TimeoutCycles + 1);
      checkOutput("tmo_err", bus.err_o, 1);
      checkOutput("tmo_idle", bus.busy_o, 0);
      applyStimulus();
      checkOutput("tmo_sticky", bus.err_o, 1);
      doClear();
      checkOutput("tmo_cleared", bus.err_o, 0);
      sarMute = 1'b0;

      $display("[TB] run enable dropped mid-burst");
      h0       = hsCount;
      s0       = startCount;
      bus.en_i = 1'b1;
      g = 0;
      while (burstCnt < 2 && g < 100) begin
         applyStimulus();
         g++;
      end
      bus.en_i = 1'b0;
      g = 0;
      while ((bus.busy_o || hsCount == h0) && g < 300) begin
         applyStimulus();
         g++;
      end
      checkOutput("drop_hs", hsCount, h0 + 1);
      checkOutput("drop_starts", startCount - s0, N);
      s0 = startCount;
      repeat (20) applyStimulus();
      checkOutput("drop_no_start", startCount - s0, 0);

      $display("[TB] clear mid-burst");
      planQ    = '{60, 60, 60, 1, 2, 3, 4};
      seenQ.delete();
      bus.en_i = 1'b1;
      g = 0;
      while (burstCnt < 3 && g < 100) begin
         applyStimulus();
         g++;
      end
      applyStimulus();
      checkOutput("clr_pre_valid", bus.valid_o, 0);
      doClear();
      checkOutput("clr_valid", bus.valid_o, 0);
      checkOutput("clr_busy", bus.busy_o, 0);
      waitHandshakes(1, 300);
      checkOutput("clr_new_avg", seenQ[0], 2);
      drainToIdle();

      $display("[TB] randomized delays and backpressure");
      randDelay = 1'b1;
      bus.en_i  = 1'b1;
      h0 = hsCount + 6;
      g  = 0;
      while (hsCount < h0 && g < 3000) begin
         bus.ready_i = 1'($urandom_range(0, 1));
         applyStimulus();
         g++;
      end
      checkOutput("rand_hs", hsCount, h0);
      drainToIdle();

      $display("[TB] asynchronous reset during WAIT");
      randDelay = 1'b0;
      eocDelay  = 8;
      s0        = startCount;
      bus.en_i  = 1'b1;
      g = 0;
      while (startCount == s0 && g < 20) begin
         applyStimulus();
         g++;
      end
      applyStimulus();
      applyStimulus();
      checkOutput("prerst_busy", bus.busy_o, 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("arst_start", bus.start_o, 0);
      checkOutput("arst_avg", bus.avg_o, 0);
      checkOutput("arst_valid", bus.valid_o, 0);
      checkOutput("arst_err", bus.err_o, 0);
      checkOutput("arst_busy", bus.busy_o, 0);
      bus.en_i = 1'b0;
      resetModel();
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus();
      checkOutput("postrst_busy", bus.busy_o, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
